// File: rtl/median3x3_stream_if.sv
// Pixel stream bundle for the 3x3 median filter: input handshake, border
// mode select and the registered output stream.
interface median3x3_stream_if #(
    parameter int PIX_W = 8
);
    logic             border_zero;
    logic [PIX_W-1:0] image_input;
    logic             image_valid;
    logic             image_ready;
    logic [PIX_W-1:0] image_output;
    logic             output_valid;
    logic             finish;

    // Pixel source / output writer side.
    modport master (
        output border_zero, image_input, image_valid,
        input  image_ready, image_output, output_valid, finish
    );

    // Filter side.
    modport slave (
        input  border_zero, image_input, image_valid,
        output image_ready, image_output, output_valid, finish
    );
endinterface

// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter. Pixels arrive in raster order; two W-deep
// line buffers feed a 3x3 window, and each advance past the first W+1 emits
// one registered output pixel. After the last input pixel the block injects
// W+1 internal advances to drain the window, then pulses finish with the
// last output.
module median3x3_stream #(
    parameter int IMG_WIDTH  = 410,
    parameter int IMG_HEIGHT = 361,
    parameter int PIX_W      = 8
) (
    input logic               clk,
    input logic               rst,
    median3x3_stream_if.slave bus
);
    localparam int N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int CNT_W = $clog2(N + IMG_WIDTH + 1);

    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_ADV  = CNT_W'(N + IMG_WIDTH);
    localparam logic [CNT_W-1:0] FIRST_OUT = CNT_W'(IMG_WIDTH + 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic {STREAM, FLUSH} state_e;
    typedef logic [PIX_W-1:0] pix_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  adv_cnt_q, adv_cnt_d;     // advances in this frame
    logic [COL_W-1:0]  ptr_q, ptr_d;             // shared line-buffer slot
    logic [COL_W-1:0]  out_col_q, out_col_d;     // column of next output
    logic [ROW_W-1:0]  out_row_q, out_row_d;     // row of next output
    logic              border_zero_q, border_zero_d;
    pix_t              image_output_q, image_output_d;
    logic              output_valid_q, output_valid_d;
    logic              finish_q, finish_d;

    logic              ready;
    logic              accept;
    logic              advance;
    logic              emit;
    logic              is_border;
    pix_t              new_pix;

    // lb_mid delays the stream by one row, lb_top by two rows.
    pix_t              lb_mid [IMG_WIDTH];
    pix_t              lb_top [IMG_WIDTH];
    pix_t              win_q  [3][3];
    pix_t              win_d  [3][3];
    pix_t              win_lin [9];

    // Median of nine by odd-even transposition sort; nine passes fully sort.
    function automatic pix_t median9(input pix_t w [9]);
        pix_t v [9];
        pix_t t;
        v = w;
        for (int pass = 0; pass < 9; pass++) begin
            for (int i = pass % 2; i < 8; i += 2) begin
                if (v[i] > v[i+1]) begin
                    t      = v[i];
                    v[i]   = v[i+1];
                    v[i+1] = t;
                end
            end
        end
        return v[4];
    endfunction

    // Handshake, FSM next state and advance/output counters.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d       = state_q;
        adv_cnt_d     = adv_cnt_q;
        ptr_d         = ptr_q;
        out_col_d     = out_col_q;
        out_row_d     = out_row_q;
        border_zero_d = border_zero_q;
        ready         = 1'b0;
        accept        = 1'b0;
        advance       = 1'b0;

        case (state_q)
            STREAM: begin
                ready   = ~rst;
                accept  = ready & bus.image_valid;
                advance = accept;
                if (accept) begin
                    adv_cnt_d = adv_cnt_q + 1'b1;
                    if (adv_cnt_q == '0) border_zero_d = bus.border_zero;
                    if (adv_cnt_q == LAST_PIX) state_d = FLUSH;
                end
            end
            FLUSH: begin
                advance = ~rst;
                if (adv_cnt_q == LAST_ADV) begin
                    state_d   = STREAM;
                    adv_cnt_d = '0;
                end else begin
                    adv_cnt_d = adv_cnt_q + 1'b1;
                end
            end
            default: state_d = STREAM;
        endcase

        emit = advance && (adv_cnt_q >= FIRST_OUT);

        if (advance) ptr_d = (ptr_q == LAST_COL) ? '0 : ptr_q + 1'b1;

        if (emit) begin
            if (out_col_q == LAST_COL) begin
                out_col_d = '0;
                out_row_d = (out_row_q == LAST_ROW) ? '0 : out_row_q + 1'b1;
            end else begin
                out_col_d = out_col_q + 1'b1;
            end
        end
    end

    // Next window contents and the output pixel they produce.
    always_comb begin
        new_pix = (state_q == STREAM) ? bus.image_input : '0;

        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb_top[ptr_q];
        win_d[1][2] = lb_mid[ptr_q];
        win_d[2][2] = new_pix;

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                win_lin[r*3 + c] = win_d[r][c];

        is_border = (out_row_q == '0) || (out_row_q == LAST_ROW) ||
                    (out_col_q == '0) || (out_col_q == LAST_COL);

        image_output_d = image_output_q;
        output_valid_d = 1'b0;
        finish_d       = 1'b0;
        if (emit) begin
            output_valid_d = 1'b1;
            finish_d       = (out_row_q == LAST_ROW) && (out_col_q == LAST_COL);
            if (is_border)
                image_output_d = border_zero_q ? '0 : win_d[1][1];
            else
                image_output_d = median9(win_lin);
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so all registers update from pre-edge values.
        if (rst) begin
            state_q        <= STREAM;
            adv_cnt_q      <= '0;
            ptr_q          <= '0;
            out_col_q      <= '0;
            out_row_q      <= '0;
            border_zero_q  <= 1'b0;
            image_output_q <= '0;
            output_valid_q <= 1'b0;
            finish_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            adv_cnt_q      <= adv_cnt_d;
            ptr_q          <= ptr_d;
            out_col_q      <= out_col_d;
            out_row_q      <= out_row_d;
            border_zero_q  <= border_zero_d;
            image_output_q <= image_output_d;
            output_valid_q <= output_valid_d;
            finish_q       <= finish_d;
        end
    end

    // Line buffers and window shift once per advance.
    always_ff @(posedge clk) begin
        // NOTE: pixel storage is not reset; stale data can only reach border outputs, which use the centre pixel.
        if (advance) begin
            lb_mid[ptr_q] <= new_pix;
            lb_top[ptr_q] <= lb_mid[ptr_q];
            win_q         <= win_d;
        end
    end

    assign bus.image_ready  = ready;
    assign bus.image_output = image_output_q;
    assign bus.output_valid = output_valid_q;
    assign bus.finish       = finish_q;
endmodule

// File: tb/tb_median3x3_stream.sv
// Directed bench for median3x3_stream on a 5x4 frame.
module tb_median3x3_stream;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    median3x3_stream_if #(.PIX_W(PW)) bus ();

    median3x3_stream #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIX_W     (PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc6_cyc = -1;
    int          first_out_cyc = -1;
    int          ready_low = 0;
    int          finish_cnt = 0;
    logic [PW-1:0] out_q [$];
    logic          fin_q [$];
    logic [PW-1:0] frame_pix [N];
    logic [PW-1:0] exp_pix [2*N];

    always @(posedge clk) cyc <= cyc + 1;

    // Output capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.output_valid) begin
            out_q.push_back(bus.image_output);
            fin_q.push_back(bus.finish);
            if (first_out_cyc < 0) first_out_cyc = cyc;
        end
        if (bus.finish) finish_cnt++;
        if (!rst && !bus.image_ready) ready_low++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_monitor();
        out_q.delete();
        fin_q.delete();
        ready_low     = 0;
        finish_cnt    = 0;
        first_out_cyc = -1;
        acc6_cyc      = -1;
    endtask

    // Drives npix pixels of frame_pix; border_zero is bz only on pixel 0.
    task automatic send_frame(input logic bz, input bit gaps, input int npix);
        bit acc;
        int waited;
        for (int k = 0; k < npix; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 0) begin
                    bus.image_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            bus.image_valid = 1'b1;
            bus.image_input = frame_pix[k];
            bus.border_zero = (k == 0) ? bz : ~bz;
            acc    = 1'b0;
            waited = 0;
            while (!acc && waited < 50) begin
                @(negedge clk);
                acc = bus.image_ready;
                if (acc && k == 6) acc6_cyc = cyc;
                @(posedge clk); #1;
                waited++;
            end
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: pixel %0d not accepted, ready=%0b expected 1", k, bus.image_ready);
                break;
            end
        end
        bus.image_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int cnt);
        int t = 0;
        while (out_q.size() < cnt && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (12) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.image_valid = 1'b1;
        bus.image_input = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.image_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b expected 0", bus.image_ready); end
        n_checks++; if (bus.output_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus.output_valid); end
        n_checks++; if (bus.image_output !== 8'd0) begin n_fail++; $display("FAIL reset_output: got %0d expected 0", bus.image_output); end
        n_checks++; if (bus.finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %0b expected 0", bus.finish); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.image_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.image_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %0b expected 1", bus.image_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_ramp_passthrough();
        for (int k = 0; k < N; k++) begin frame_pix[k] = PW'(k); exp_pix[k] = PW'(k); end
        clear_monitor();
        send_frame(1'b0, 1'b0, N);
        wait_outputs(N);
        n_checks++; if (first_out_cyc !== acc6_cyc + 1) begin n_fail++; $display("FAIL ramp_latency: first output cycle %0d expected %0d", first_out_cyc, acc6_cyc + 1); end
        n_checks++; if (out_q.size() !== N) begin n_fail++; $display("FAIL ramp_count: got %0d expected %0d", out_q.size(), N); end
        for (int j = 0; j < N; j++) begin
            n_checks++;
            if (j >= out_q.size() || out_q[j] !== exp_pix[j]) begin
                n_fail++;
                $display("FAIL ramp_pix[%0d]: got %0d expected %0d", j, (j < out_q.size()) ? out_q[j] : 8'hxx, exp_pix[j]);
            end
        end
        n_checks++; if (ready_low !== W + 1) begin n_fail++; $display("FAIL ramp_ready_low: got %0d cycles expected %0d", ready_low, W + 1); end
        n_checks++; if (finish_cnt !== 1) begin n_fail++; $display("FAIL ramp_finish_cnt: got %0d expected 1", finish_cnt); end
        n_checks++; if (fin_q.size() != N || fin_q[N-1] !== 1'b1) begin n_fail++; $display("FAIL ramp_finish_last: finish not on output %0d", N - 1); end
    endtask

    task automatic test_ramp_zero();
        logic [PW-1:0] e [N] = '{0,0,0,0,0, 0,6,7,8,0, 0,11,12,13,0, 0,0,0,0,0};
        for (int k = 0; k < N; k++) frame_pix[k] = PW'(k);
        clear_monitor();
        send_frame(1'b1, 1'b0, N);
        wait_outputs(N);
        n_checks++; if (out_q.size() !== N) begin n_fail++; $display("FAIL zero_count: got %0d expected %0d", out_q.size(), N); end
        for (int j = 0; j < N; j++) begin
            n_checks++;
            if (j >= out_q.size() || out_q[j] !== e[j]) begin
                n_fail++;
                $display("FAIL zero_pix[%0d]: got %0d expected %0d", j, (j < out_q.size()) ? out_q[j] : 8'hxx, e[j]);
            end
        end
        n_checks++; if (finish_cnt !== 1) begin n_fail++; $display("FAIL zero_finish_cnt: got %0d expected 1", finish_cnt); end
    endtask

    task automatic test_impulse();
        for (int k = 0; k < N; k++) frame_pix[k] = 8'd10;
        frame_pix[1*W + 1] = 8'd0;
        frame_pix[2*W + 2] = 8'd255;
        clear_monitor();
        send_frame(1'b0, 1'b0, N);
        wait_outputs(N);
        n_checks++; if (out_q.size() !== N) begin n_fail++; $display("FAIL impulse_count: got %0d expected %0d", out_q.size(), N); end
        for (int j = 0; j < N; j++) begin
            n_checks++;
            if (j >= out_q.size() || out_q[j] !== 8'd10) begin
                n_fail++;
                $display("FAIL impulse_pix[%0d]: got %0d expected 10", j, (j < out_q.size()) ? out_q[j] : 8'hxx);
            end
        end
    endtask

    task automatic test_gaps();
        for (int k = 0; k < N; k++) frame_pix[k] = PW'(k);
        clear_monitor();
        send_frame(1'b0, 1'b1, N);
        wait_outputs(N);
        n_checks++; if (out_q.size() !== N) begin n_fail++; $display("FAIL gaps_count: got %0d expected %0d", out_q.size(), N); end
        for (int j = 0; j < N; j++) begin
            n_checks++;
            if (j >= out_q.size() || out_q[j] !== PW'(j)) begin
                n_fail++;
                $display("FAIL gaps_pix[%0d]: got %0d expected %0d", j, (j < out_q.size()) ? out_q[j] : 8'hxx, j);
            end
        end
        n_checks++; if (finish_cnt !== 1) begin n_fail++; $display("FAIL gaps_finish_cnt: got %0d expected 1", finish_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] e2 [N] = '{0,0,0,0,0, 0,170,165,160,0, 0,145,140,135,0, 0,0,0,0,0};
        clear_monitor();
        for (int k = 0; k < N; k++) frame_pix[k] = PW'(k);
        send_frame(1'b0, 1'b0, N);
        for (int k = 0; k < N; k++) frame_pix[k] = PW'(200 - 5 * k);
        send_frame(1'b1, 1'b0, N);
        wait_outputs(2 * N);
        for (int j = 0; j < N; j++) begin exp_pix[j] = PW'(j); exp_pix[N + j] = e2[j]; end
        n_checks++; if (out_q.size() !== 2 * N) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", out_q.size(), 2 * N); end
        for (int j = 0; j < 2 * N; j++) begin
            n_checks++;
            if (j >= out_q.size() || out_q[j] !== exp_pix[j]) begin
                n_fail++;
                $display("FAIL b2b_pix[%0d]: got %0d expected %0d", j, (j < out_q.size()) ? out_q[j] : 8'hxx, exp_pix[j]);
            end
        end
        n_checks++; if (finish_cnt !== 2) begin n_fail++; $display("FAIL b2b_finish_cnt: got %0d expected 2", finish_cnt); end
        n_checks++; if (fin_q.size() != 2 * N || fin_q[N-1] !== 1'b1 || fin_q[2*N-1] !== 1'b1) begin n_fail++; $display("FAIL b2b_finish_pos: finish not on outputs %0d and %0d", N - 1, 2 * N - 1); end
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < N; k++) frame_pix[k] = PW'(k);
        clear_monitor();
        send_frame(1'b0, 1'b0, 13);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.image_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %0b expected 0", bus.image_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.output_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b expected 0", bus.output_valid); end
        repeat (20) @(negedge clk);
        n_checks++; if (out_q.size() !== 7) begin n_fail++; $display("FAIL midrst_partial_count: got %0d expected 7", out_q.size()); end
        n_checks++; if (finish_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_finish: got %0d expected 0", finish_cnt); end
        @(posedge clk); #1;
        clear_monitor();
        send_frame(1'b0, 1'b0, N);
        wait_outputs(N);
        n_checks++; if (out_q.size() !== N) begin n_fail++; $display("FAIL midrst_count: got %0d expected %0d", out_q.size(), N); end
        for (int j = 0; j < N; j++) begin
            n_checks++;
            if (j >= out_q.size() || out_q[j] !== PW'(j)) begin
                n_fail++;
                $display("FAIL midrst_pix[%0d]: got %0d expected %0d", j, (j < out_q.size()) ? out_q[j] : 8'hxx, j);
            end
        end
        n_checks++; if (finish_cnt !== 1) begin n_fail++; $display("FAIL midrst_finish_cnt: got %0d expected 1", finish_cnt); end
    endtask

    initial begin
        bus.image_valid = 1'b0;
        bus.image_input = '0;
        bus.border_zero = 1'b0;
        test_reset();
        test_ramp_passthrough();
        test_ramp_zero();
        test_impulse();
        test_gaps();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
